traffic_ctrl: RTL
=================

# traffic_ctrl

- Sequencing controller for a highway/farm-road intersection; it owns the shared `timer` block.
- Drives both light heads and an optional pedestrian walk signal.
- Restarts the timer through `timer_hw_reset` on every phase change.
- Uses the timer's `short_timeout` and `long_timeout` flags to pace each phase.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `farm_car`  in  1  farm-road vehicle sensor, level, synchronous to `clk`.
- `ped_btn`  in  1  pedestrian request, single-cycle pulse or level (present only with `TRAFFIC_PED_EN`, see Configuration).
- `short_timeout`  in  1  from timer; high once the timer count is ≥ 3.
- `long_timeout`  in  1  from timer; high once the timer count is 7.
- `timer_hw_reset`  out  1  registered; restarts the timer.
- `hw_light`  out  2  highway head: 2'b00 red, 2'b01 yellow, 2'b10 green.
- `farm_light`  out  2  farm head, same encoding as `hw_light`.
- `walk`  out  1  pedestrian walk lamp.
- `fsm_state`  out  3  current state encoding, for debug and firmware visibility.

## Operation
States and encodings: HG=0, HY=1, AR_F=2, FG=3, FY=4, AR_H=5, WALK=6; 7 is illegal.

Lights per state:
- HG: highway green, farm red.
- HY: highway yellow, farm red.
- FG: highway red, farm green.
- FY: highway red, farm yellow.
- AR_F, AR_H, WALK: both heads red.
- `walk`=1 only in WALK.

Qualified timeouts:
- `st` = `short_timeout` & ~`timer_hw_reset`.
- `lt` = `long_timeout` & ~`timer_hw_reset`.
- Masking is required: in the first cycle of a new state the timer still holds the previous phase's count.

Transitions:
- HG → HY when `lt` & (`farm_car` | `ped_pending`).
- HY → AR_F when `st`.
- AR_F → WALK when `st` & `ped_pending`; AR_F → FG when `st` & ~`ped_pending`.
- WALK → FG when `lt` & `farm_car`; WALK → AR_H when `lt` & ~`farm_car`.
- FG → FY when `lt` | (`st` & ~`farm_car`). This gives a minimum green, then early exit once the road is empty.
- FY → AR_H when `st`.
- AR_H → HG when `st`.
- Illegal state 7 → AR_H on the next edge, with `timer_hw_reset` asserted.

Timer restart:
- `timer_hw_reset` is registered and high for exactly the first cycle of every newly entered state (next-state ≠ state).
- It is low while the state holds.

Pedestrian latch:
- `ped_pending` is set on any cycle with `ped_btn`=1.
- It is cleared on the edge that enters WALK.
- If set and clear happen in the same cycle, clear wins: the request is consumed by this WALK.
- A press during WALK is latched and serviced in the next cycle through HG.

Reset:
- Asynchronous entry to HG.
- Reset values: `hw_light`=2'b10, `farm_light`=2'b00, `walk`=0, `timer_hw_reset`=1, `ped_pending`=0, `fsm_state`=0.
- On the first edge after deassertion, `timer_hw_reset` drops to 0.
- Reset asserted mid-phase aborts immediately to HG, including from yellow or WALK.

## Timing
- All outputs are registered or decoded from registered state; no input reaches an output combinationally.
- With the companion timer, and a state entered at cycle 0:
  - The timer is in its reset state at cycle 1.
  - `short_timeout` rises at cycle 4, so a short-paced state lasts 5 cycles.
  - `long_timeout` rises at cycle 8, so a long-paced state lasts at least 9 cycles.
- Phase durations:
  - HY, FY, AR_F, AR_H: exactly 5 cycles each.
  - HG, WALK: at least 9 cycles.
  - FG: 5 to 9 cycles.
- `farm_car` and `ped_pending` are sampled on the same edge that sees the qualifying timeout.
- A firmware timer reset from elsewhere simply extends the current phase; the controller does not observe it.

## Configuration
`TRAFFIC_PED_EN`:
- Defined: the `ped_btn` port, the `ped_pending` latch and the WALK state are present, as described above.
- Undefined:
  - No `ped_btn` port.
  - `ped_pending` is the constant 0; HG exits on `lt` & `farm_car` only.
  - AR_F always goes to FG.
  - `walk` is tied to 0.
  - Encoding 6 is treated as illegal and recovers to AR_H.

## Test plan
- Reset, then `farm_car`=0 for 40 cycles → HG held throughout; `timer_hw_reset`=1 only in the first post-reset cycle.
- `farm_car` held at 1 from reset → HG for 9 cycles, HY 5, AR_F 5, FG 9 (long exit), FY 5, AR_H 5, back to HG. `timer_hw_reset` pulses once at each of the 6 state changes.
- `farm_car`=1 until cycle 2 of FG, then 0 → FG lasts 5 cycles (`st` exit), then FY.
- `TRAFFIC_PED_EN`: `ped_btn` pulse at cycle 3 of HG, `farm_car`=0 → HY, AR_F, then WALK (`walk`=1 for 9 cycles), AR_H, HG; `ped_pending` is cleared on WALK entry.
- Reset asserted at cycle 2 of FY → outputs go to HG values asynchronously; after release the timer is restarted and the full HG duration applies.
- Force the state register to 7 → one cycle later `fsm_state`=5 with `timer_hw_reset`=1; then HG 5 cycles later.

Source files
------------

// File: rtl/traffic_ctrl.sv
// traffic_ctrl: highway/farm-road intersection sequencer that paces each phase off the shared timer.
// Define TRAFFIC_PED_EN to build in the pedestrian request latch and the WALK phase.
module traffic_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       farm_car,
`ifdef TRAFFIC_PED_EN
  input  logic       ped_btn,
`endif
  input  logic       short_timeout,
  input  logic       long_timeout,
  output logic       timer_hw_reset,
  output logic [1:0] hw_light,
  output logic [1:0] farm_light,
  output logic       walk,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    StHg   = 3'd0,
    StHy   = 3'd1,
    StArF  = 3'd2,
    StFg   = 3'd3,
    StFy   = 3'd4,
    StArH  = 3'd5,
    StWalk = 3'd6
  } state_e;

  localparam logic [1:0] LightRed    = 2'b00;
  localparam logic [1:0] LightYellow = 2'b01;
  localparam logic [1:0] LightGreen  = 2'b10;

  // Plain vector rather than state_e so an out-of-range encoding can exist and be recovered.
  logic [2:0] r_state;
  logic [2:0] w_next;
  logic       r_timer_hw_reset;
  logic [1:0] r_hw_light;
  logic [1:0] r_farm_light;
  logic       w_st;
  logic       w_lt;
  logic       w_ped_pending;

  // The timer still holds the previous phase's count during the first cycle of a new state.
  assign w_st = short_timeout & ~r_timer_hw_reset;
  assign w_lt = long_timeout & ~r_timer_hw_reset;

  function automatic logic [1:0] hw_light_of(logic [2:0] s);
    case (s)
      StHg:    return LightGreen;
      StHy:    return LightYellow;
      default: return LightRed;
    endcase
  endfunction

  function automatic logic [1:0] farm_light_of(logic [2:0] s);
    case (s)
      StFg:    return LightGreen;
      StFy:    return LightYellow;
      default: return LightRed;
    endcase
  endfunction

  always_comb begin
    w_next = r_state;
    case (r_state)
      StHg:   if (w_lt && (farm_car || w_ped_pending)) w_next = StHy;
      StHy:   if (w_st) w_next = StArF;
      StArF:  if (w_st) w_next = w_ped_pending ? StWalk : StFg;
      StFg:   if (w_lt || (w_st && !farm_car)) w_next = StFy;
      StFy:   if (w_st) w_next = StArH;
      StArH:  if (w_st) w_next = StHg;
`ifdef TRAFFIC_PED_EN
      StWalk: if (w_lt) w_next = farm_car ? StFg : StArH;
`endif
      default: w_next = StArH;
    endcase
  end

`ifdef TRAFFIC_PED_EN
  logic r_ped_pending;
  logic r_walk;

  assign w_ped_pending = r_ped_pending;
  assign walk          = r_walk;
`else
  assign w_ped_pending = 1'b0;
  assign walk          = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= StHg;
      r_timer_hw_reset <= 1'b1;
      r_hw_light       <= LightGreen;
      r_farm_light     <= LightRed;
`ifdef TRAFFIC_PED_EN
      r_ped_pending    <= 1'b0;
      r_walk           <= 1'b0;
`endif
    end else begin
      r_state          <= w_next;
      r_timer_hw_reset <= (w_next != r_state);
      r_hw_light       <= hw_light_of(w_next);
      r_farm_light     <= farm_light_of(w_next);
`ifdef TRAFFIC_PED_EN
      // Entering WALK consumes the request, even one pressed on that same cycle.
      if (w_next == StWalk && r_state != StWalk) r_ped_pending <= 1'b0;
      else                                       r_ped_pending <= r_ped_pending | ped_btn;
      r_walk           <= (w_next == StWalk);
`endif
    end
  end

  assign timer_hw_reset = r_timer_hw_reset;
  assign hw_light       = r_hw_light;
  assign farm_light     = r_farm_light;
  assign fsm_state      = r_state;

endmodule
